// File: rtl/booth_mult_sequencer_if.sv
// Bundle between the HI/LO multiply control, the Booth partial-product datapath and the sequencer.
// master = control + datapath side, slave = sequencer.
interface booth_mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   shift_a;
  logic [1:0]           sel_booth_b;
  logic                 sign;
  logic [2*WIDTH-1:0]   partial_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_op, multiplicand, multiplier, partial_in,
    input  shift_a, sel_booth_b, sign, busy, done, product
  );

  modport slave (
    input  start, signed_op, multiplicand, multiplier, partial_in,
    output shift_a, sel_booth_b, sign, busy, done, product
  );
endinterface

// File: rtl/booth_mult_sequencer.sv
// Radix-4 Booth multiply sequencer: scans one multiplier digit per cycle, drives the shared
// shifter/negator and accumulates its result; Start accepted in IDLE only, Done 18 cycles later.
module booth_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  booth_mult_sequencer_if.slave bus
);

  localparam int NDIG = WIDTH / 2;
  localparam int KW   = $clog2(NDIG + 1);
  localparam int PW   = 2 * WIDTH;
  localparam int QW   = WIDTH + 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {sign, sel[1:0]} for a Booth window {q[2k+1], q[2k], q[2k-1]}
  function automatic logic [2:0] booth_enc(input logic [2:0] win);
    logic [2:0] code;
    case (win)
      3'b001, 3'b010: code = 3'b001;
      3'b011:         code = 3'b010;
      3'b100:         code = 3'b110;
      3'b101, 3'b110: code = 3'b101;
      default:        code = 3'b000;
    endcase
    return code;
  endfunction

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [QW-1:0]   r_q;
  logic [PW-1:0]   r_shift_a;
  logic [1:0]      r_sel;
  logic            r_sign;
  logic            r_busy;
  logic            r_done;
  logic [PW-1:0]   r_product;

  logic            w_ext_q;
  logic            w_ext_a;
  logic [QW-1:0]   w_q_ext;
  logic [PW-1:0]   w_ea;
  logic [2:0]      w_enc_start;
  logic [2:0]      w_enc_next;
  logic            w_last;

  // Q carries two extension bits above the operand and the implicit Q[-1]=0 at bit 0
  assign w_ext_q     = bus.signed_op & bus.multiplier[WIDTH-1];
  assign w_ext_a     = bus.signed_op & bus.multiplicand[WIDTH-1];
  assign w_q_ext     = {{2{w_ext_q}}, bus.multiplier, 1'b0};
  assign w_ea        = {{WIDTH{w_ext_a}}, bus.multiplicand};
  assign w_enc_start = booth_enc(w_q_ext[2:0]);
  assign w_enc_next  = booth_enc(r_q[4:2]);
  assign w_last      = (r_k == KW'(NDIG));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_q       <= '0;
      r_shift_a <= '0;
      r_sel     <= '0;
      r_sign    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state   <= ST_RUN;
            r_k       <= '0;
            r_q       <= w_q_ext;
            r_shift_a <= w_ea;
            r_sign    <= w_enc_start[2];
            r_sel     <= w_enc_start[1:0];
            r_busy    <= 1'b1;
            r_product <= '0;
          end
        end
        ST_RUN: begin
          r_product <= r_product + bus.partial_in;
          if (w_last) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_shift_a <= '0;
            r_sel     <= '0;
            r_sign    <= 1'b0;
          end else begin
            // Outputs are registered, so the next digit is prepared from the current window + 2
            r_k       <= r_k + KW'(1);
            r_q       <= r_q >> 2;
            r_shift_a <= r_shift_a << 2;
            r_sign    <= w_enc_next[2];
            r_sel     <= w_enc_next[1:0];
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shift_a     = r_shift_a;
  assign bus.sel_booth_b = r_sel;
  assign bus.sign        = r_sign;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.product     = r_product;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer: directed multiplies with hand-computed products and digit codes,
// a behavioural shifter/negator, and a scoreboard monitor that checks every RUN and DONE cycle.
module tb_booth_mult_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [63:0] prod;
    logic [63:0] ea;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_sequencer_if #(.WIDTH(W)) bus ();

  booth_mult_sequencer #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          run_cnt = 0;
  logic [63:0] dp_mult;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Shifter/negator model returning the partial product in the same cycle
  always_comb begin
    dp_mult = 64'd0;
    case (bus.sel_booth_b)
      2'd1:    dp_mult = bus.shift_a;
      2'd2:    dp_mult = bus.shift_a << 1;
      default: dp_mult = 64'd0;
    endcase
    bus.partial_in = bus.sign ? (~dp_mult + 64'd1) : dp_mult;
  end

  always @(negedge clk) begin
    if (rst) begin
      run_cnt = 0;
    end else if (bus.busy) begin
      check("sel_code_legal",
            {63'd0, (bus.sel_booth_b == 2'd3) || (bus.sel_booth_b == 2'd0 && bus.sign)}, 64'd0);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL run_without_start: busy=%b, expected no activity", bus.busy);
      end else begin
        check("shift_a", bus.shift_a, sb_q[0].ea << (2 * run_cnt));
      end
      run_cnt++;
    end else if (bus.done) begin
      check("run_length", 64'(run_cnt), 64'd17);
      check("done_sel_sign", {61'd0, bus.sign, bus.sel_booth_b}, 64'd0);
      check("done_shift_a", bus.shift_a, 64'd0);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done=%b, expected 0", bus.done);
      end else begin
        mon_e = sb_q.pop_front();
        check("product", bus.product, mon_e.prod);
      end
      run_cnt = 0;
    end else begin
      run_cnt = 0;
    end
  end

  task automatic run_vec(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input logic [2:0] d0, input logic [2:0] d1,
                         input bit pulses);
    exp_t e;
    int   cyc;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.signed_op    = sgn;
    bus.multiplicand = a;
    bus.multiplier   = b;
    e.prod = expv;
    e.ea   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_cycle1", {63'd0, bus.busy}, 64'd1);
    check("digit0", {61'd0, bus.sign, bus.sel_booth_b}, {61'd0, d0});
    // Scramble operands so the run must rely on the latched copies
    bus.multiplicand = ~a;
    bus.multiplier   = ~b;
    bus.signed_op    = ~sgn;
    @(negedge clk);
    cyc = 2;
    check("digit1", {61'd0, bus.sign, bus.sel_booth_b}, {61'd0, d1});
    while (!bus.done && cyc < 40) begin
      bus.start = pulses && (cyc == 3 || cyc == 10);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_cycle", 64'(cyc), 64'd18);
    if (pulses) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_in_done_ignored", {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      check("still_idle", {63'd0, bus.busy}, 64'd0);
      check("product_held", bus.product, expv);
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.signed_op    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    check("rst_product", bus.product, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_shift_a", bus.shift_a, 64'd0);
    check("rst_sel_sign", {61'd0, bus.sign, bus.sel_booth_b}, 64'd0);
    rst = 1'b0;

    //      sgn   multiplicand  multiplier    product                 d0      d1
    run_vec(1'b0, 32'h00000003, 32'h00000005, 64'h000000000000000F, 3'b001, 3'b001, 1'b1);
    run_vec(1'b0, 32'h00000005, 32'h00000003, 64'h000000000000000F, 3'b101, 3'b001, 1'b0);
    run_vec(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 3'b101, 3'b000, 1'b0);
    run_vec(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 3'b101, 3'b000, 1'b0);
    run_vec(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 3'b000, 3'b000, 1'b0);
    run_vec(1'b1, 32'h7FFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFF00000002, 3'b110, 3'b000, 1'b0);
    run_vec(1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB, 3'b101, 3'b010, 1'b0);
    run_vec(1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000, 3'b110, 3'b001, 1'b0);
    run_vec(1'b0, 32'hAAAAAAAA, 32'h00000003, 64'h00000001FFFFFFFE, 3'b101, 3'b001, 1'b0);
    run_vec(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 3'b101, 3'b000, 1'b0);
    run_vec(1'b1, 32'h00000000, 32'h12345678, 64'h0000000000000000, 3'b000, 3'b110, 1'b0);
    run_vec(1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000, 3'b000, 3'b000, 1'b0);
    run_vec(1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 3'b001, 3'b000, 1'b0);
    run_vec(1'b0, 32'h80000000, 32'h00000001, 64'h0000000080000000, 3'b001, 3'b000, 1'b0);

    // Abort a run with reset in RUN cycle 8
    @(negedge clk);
    bus.start        = 1'b1;
    bus.signed_op    = 1'b0;
    bus.multiplicand = 32'd3;
    bus.multiplier   = 32'd5;
    sb_q.push_back('{prod: 64'd15, ea: 64'd3});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_before_abort", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb_q.pop_front());
    check("abort_product", bus.product, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_sel_sign", {61'd0, bus.sign, bus.sel_booth_b}, 64'd0);
    repeat (25) @(negedge clk);
    run_vec(1'b0, 32'h00000003, 32'h00000005, 64'h000000000000000F, 3'b001, 3'b001, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
